cosim_trace_sequencer: RTL and testbench

COSIM_TRACE_SEQUENCER -- requirements
Module: cosim_trace_sequencer

---
 rtl/cosim_trace_sequencer.sv | 136 +++++++++++++
 tb/tb_cosim_trace_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cosim_trace_sequencer.sv
// Dual-lane retire trace queue feeding a lockstep co-simulation checker.
// Two enqueues and one first-word-fall-through dequeue per cycle.
module cosim_trace_sequencer #(
    parameter int TRACE_W = 256,
    parameter int DEPTH   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       in_ready,
    input  logic                       in0_fire,
    input  logic [TRACE_W-1:0]         in0_rec,
    input  logic                       in1_fire,
    input  logic [TRACE_W-1:0]         in1_rec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TRACE_W-1:0]         out_rec,
    output logic                       out_lane,
    output logic [63:0]                out_seq,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TRACE_W-1:0] mem_q  [DEPTH];
    logic               lane_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   seq_q, seq_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;

    logic               wr0_en, wr1_en;
    logic [PW-1:0]      wr0_addr, wr1_addr;
    logic [TRACE_W-1:0] wr0_data, wr1_data;
    logic               wr0_lane, wr1_lane;

    logic          accept;
    logic          pop;
    logic [1:0]    n_fire;
    logic [16:0]   drop_sum;

    assign in_ready  = (count_q <= CW'(DEPTH - 2));
    assign out_valid = (count_q != '0);
    assign out_rec   = mem_q[head_q];
    assign out_lane  = lane_q[head_q];
    assign out_seq   = seq_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

    assign n_fire = {1'b0, in0_fire} + {1'b0, in1_fire};
    assign accept = in_ready && (n_fire != 2'd0);
    assign pop    = out_valid && out_ready;

    always_comb begin
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_addr = tail_q;
        wr1_addr = tail_q + PW'(1);
        wr0_data = in0_rec;
        wr1_data = in1_rec;
        wr0_lane = 1'b0;
        wr1_lane = 1'b1;
        // A lone lane-1 event takes the tail slot so no hole is left.
        if (accept) begin
            if (in0_fire) begin
                wr0_en = 1'b1;
                wr1_en = in1_fire;
            end else begin
                wr0_en   = 1'b1;
                wr0_data = in1_rec;
                wr0_lane = 1'b1;
            end
        end
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        seq_d    = seq_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        drop_sum = {1'b0, drop_q} + 17'(n_fire);
        if (accept) begin
            tail_d = tail_q + PW'(n_fire);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
            seq_d  = seq_q + 64'd1;
        end
        count_d = count_q + (accept ? CW'(n_fire) : CW'(0)) - CW'(pop);
        if (!in_ready && (n_fire != 2'd0)) begin
            ovf_d  = 1'b1;
            drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Storage is not cleared; stale slots are unreachable once pointers reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (wr0_en) begin
                mem_q[wr0_addr]  <= wr0_data;
                lane_q[wr0_addr] <= wr0_lane;
            end
            if (wr1_en) begin
                mem_q[wr1_addr]  <= wr1_data;
                lane_q[wr1_addr] <= wr1_lane;
            end
        end
    end

endmodule

// File: tb/tb_cosim_trace_sequencer.sv
// Directed bench for cosim_trace_sequencer, DEPTH=8.
module tb_cosim_trace_sequencer;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_ready;
    logic         in0_fire, in1_fire;
    logic [255:0] in0_rec, in1_rec;
    logic         out_valid, out_ready;
    logic [255:0] out_rec;
    logic         out_lane;
    logic [63:0]  out_seq;
    logic [3:0]   count;
    logic         overflow;
    logic [15:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    cosim_trace_sequencer #(.TRACE_W(256), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .in_ready(in_ready),
        .in0_fire(in0_fire), .in0_rec(in0_rec),
        .in1_fire(in1_fire), .in1_rec(in1_rec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rec(out_rec), .out_lane(out_lane), .out_seq(out_seq),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [255:0] mk(input logic [31:0] v);
        return {8{v}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic f0, input logic [255:0] r0,
                        input logic f1, input logic [255:0] r1,
                        input logic rdy);
        in0_fire  = f0;
        in0_rec   = r0;
        in1_fire  = f1;
        in1_rec   = r1;
        out_ready = rdy;
        cyc();
        in0_fire  = 1'b0;
        in1_fire  = 1'b0;
        out_ready = 1'b0;
    endtask

    logic [255:0] exp_q [7];

    initial begin
        reset = 1'b0;
        in0_fire = 0; in1_fire = 0; out_ready = 0;
        in0_rec = '0; in1_rec = '0;
        cyc();
        cyc();
        reset = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_seq", out_seq, 0);

        // Pop on empty queue has no effect
        step(0, '0, 0, '0, 1);
        chk("empty_pop_seq", out_seq, 0);
        chk("empty_pop_cnt", count, 0);

        // Dual fire A/B
        step(1, mk(32'hAAAA0001), 1, mk(32'hBBBB0002), 0);
        chk("dual_count", count, 2);
        chk("dual_rec", out_rec, mk(32'hAAAA0001));
        chk("dual_lane", out_lane, 0);
        chk("dual_seq", out_seq, 0);
        step(0, '0, 0, '0, 1);
        chk("pop1_rec", out_rec, mk(32'hBBBB0002));
        chk("pop1_lane", out_lane, 1);
        chk("pop1_seq", out_seq, 1);
        step(0, '0, 0, '0, 1);
        chk("pop2_valid", out_valid, 0);
        chk("pop2_seq", out_seq, 2);

        // Lane-1-only fire, lane-0 record is garbage
        step(0, mk(32'hDEADBEEF), 1, mk(32'hCCCC0003), 0);
        chk("l1_rec", out_rec, mk(32'hCCCC0003));
        chk("l1_lane", out_lane, 1);
        chk("l1_count", count, 1);
        step(0, '0, 0, '0, 1);
        chk("l1_pop_cnt", count, 0);
        chk("l1_pop_seq", out_seq, 3);

        // Fill to 7 (head/tail now 3)
        step(1, mk(32'h10), 1, mk(32'h11), 0);
        step(1, mk(32'h12), 1, mk(32'h13), 0);
        step(1, mk(32'h14), 1, mk(32'h15), 0);
        chk("fill6_ready", in_ready, 1);
        step(1, mk(32'h16), 0, '0, 0);
        chk("fill7_count", count, 7);
        chk("fill7_ready", in_ready, 0);

        // Dual fire when full: both dropped
        step(1, mk(32'hE0), 1, mk(32'hE1), 0);
        chk("drop_ovf", overflow, 1);
        chk("drop_cnt", drop_cnt, 2);
        chk("drop_count", count, 7);
        chk("drop_ready", in_ready, 0);
        chk("drop_head", out_rec, mk(32'h10));

        // Drop one while a pop proceeds
        step(1, mk(32'hE2), 0, '0, 1);
        chk("droppop_cnt", drop_cnt, 3);
        chk("droppop_count", count, 6);
        chk("droppop_seq", out_seq, 4);
        chk("droppop_rec", out_rec, mk(32'h11));

        // count=6, dual push + pop -> 7, crossing the wrap
        step(1, mk(32'h20), 1, mk(32'h21), 1);
        chk("pp_count", count, 7);
        chk("pp_seq", out_seq, 5);
        exp_q = '{mk(32'h12), mk(32'h13), mk(32'h14), mk(32'h15),
                  mk(32'h16), mk(32'h20), mk(32'h21)};
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("drain_rec%0d", i), out_rec, exp_q[i]);
            step(0, '0, 0, '0, 1);
        end
        chk("drain_valid", out_valid, 0);
        chk("drain_seq", out_seq, 12);
        chk("ovf_sticky", overflow, 1);

        // Mid-operation reset with dual fire
        step(1, mk(32'h30), 1, mk(32'h31), 0);
        step(1, mk(32'h32), 1, mk(32'h33), 0);
        step(1, mk(32'h34), 0, '0, 0);
        chk("pre_rst_count", count, 5);
        reset = 1'b0;
        step(1, mk(32'h40), 1, mk(32'h41), 1);
        reset = 1'b1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_seq", out_seq, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_ready", in_ready, 1);

        step(1, mk(32'h50), 0, '0, 0);
        chk("post_rst_rec", out_rec, mk(32'h50));
        chk("post_rst_lane", out_lane, 0);
        chk("post_rst_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
